// File: rtl/rpc_phy_emu_pkg.sv
// Shared types for the RPC DRAM controller <-> PHY boundary, plus the PHY
// emulator's beat counter and FSM state encoding.
package rpc_phy_emu_pkg;

  localparam int unsigned DramAddrW = 20;
  localparam int unsigned DramWordW = 256;

  typedef logic [5:0]           dram_blen_t;
  typedef logic [DramAddrW-1:0] dram_addr_t;
  typedef logic [DramWordW-1:0] dram_word_t;

  // Remaining beats of the active burst; same width as a burst length.
  typedef dram_blen_t dram_beat_cnt_t;

  // Command channel from the controller (28 bits).
  typedef struct packed {
    logic       cmd_valid;
    logic       is_write;
    dram_blen_t len;
    dram_addr_t addr;
  } axi_cmd_req_t;

  typedef struct packed {
    logic cmd_ready;
  } axi_cmd_rsp_t;

  // Data channel from the controller (258 bits).
  typedef struct packed {
    logic       w_data_valid;
    logic       r_data_ready;
    dram_word_t w_data;
  } phy_req_t;

  // Data channel back to the controller (259 bits).
  typedef struct packed {
    logic       w_data_ready;
    logic       r_data_valid;
    dram_word_t r_data;
    logic       r_data_last;
  } phy_rsp_t;

  typedef enum logic [1:0] {
    EMU_IDLE    = 2'd0,
    EMU_WR      = 2'd1,
    EMU_RD_WAIT = 2'd2,
    EMU_RD_DATA = 2'd3
  } emu_state_e;

endpackage

// File: rtl/rpc_emu_mem.sv
// Single-port word memory for the PHY emulator. One write or one read per
// cycle; read data appears one cycle after the address and holds until the
// next read, which lets it double as the read-data output register.
module rpc_emu_mem #(
  parameter  int unsigned Depth = 1024,
  parameter  int unsigned Width = 256,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_addr,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  // Write-first-free single-port RAM with registered read (BRAM template).
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rpc_phy_emu.sv
// PHY/DRAM stand-in for the RPC DRAM controller. Accepts burst commands,
// sinks write beats into a word memory and returns read beats after a
// programmable latency.
//
// Handshake rule for every channel: a beat transfers at the rising edge where
// valid and ready are both high. All ready outputs here come from registers
// decoded by FSM state and never look at the incoming valid signals.
module rpc_phy_emu
  import rpc_phy_emu_pkg::*;
#(
  parameter int unsigned Depth       = 1024,
  parameter int unsigned ReadLatency = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  axi_cmd_req_t cmd_req_i,
  output axi_cmd_rsp_t cmd_rsp_o,
  input  phy_req_t     phy_req_i,
  output phy_rsp_t     phy_rsp_o,
  output emu_state_e   dbg_state_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned LatW = (ReadLatency > 0) ? $clog2(ReadLatency + 1) : 1;

  emu_state_e     r_state;
  dram_beat_cnt_t r_cnt;
  logic [IdxW-1:0] r_ptr;
  logic [LatW-1:0] r_lat;
  logic           r_cmd_ready;
  logic           r_wready;
  logic           r_rvalid;
  logic           r_rlast;

  logic            w_cmd_fire;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic            w_cnt_last;
  logic            w_fetch_first;
  logic            w_fetch_next;
  logic            w_mem_en;
  logic [IdxW-1:0] w_mem_addr;
  logic [IdxW-1:0] w_cmd_idx;
  dram_word_t      w_mem_rdata;
  logic            w_unused_addr;

  // Upper address bits select nothing: the word index wraps modulo Depth.
  assign w_cmd_idx     = cmd_req_i.addr[IdxW-1:0];
  assign w_unused_addr = ^cmd_req_i.addr;

  assign w_cmd_fire    = r_cmd_ready & cmd_req_i.cmd_valid;
  assign w_wr_fire     = r_wready & phy_req_i.w_data_valid & ~rst_i;
  assign w_rd_fire     = r_rvalid & phy_req_i.r_data_ready;
  assign w_cnt_last    = (r_cnt == dram_beat_cnt_t'(1));

  // First fetch leaves RD_WAIT; later fetches ride on the current beat's
  // handshake so the next word is ready one cycle later (1 beat per cycle).
  assign w_fetch_first = (r_state == EMU_RD_WAIT) && (r_lat == '0) && !rst_i;
  assign w_fetch_next  = w_rd_fire && !w_cnt_last && !rst_i;
  assign w_mem_en      = w_wr_fire | w_fetch_first | w_fetch_next;
  assign w_mem_addr    = w_fetch_next ? (r_ptr + IdxW'(1)) : r_ptr;

  rpc_emu_mem #(
    .Depth (Depth),
    .Width (DramWordW)
  ) u_mem (
    .i_clk   (clk_i),
    .i_en    (w_mem_en),
    .i_we    (w_wr_fire),
    .i_addr  (w_mem_addr),
    .i_wdata (phy_req_i.w_data),
    .o_rdata (w_mem_rdata)
  );

  // Burst FSM: state, counters and all handshake outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= EMU_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_lat       <= '0;
      r_cmd_ready <= 1'b1;
      r_wready    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
    end else begin
      case (r_state)
        EMU_IDLE: begin
          if (w_cmd_fire) begin
            r_cnt <= cmd_req_i.len;
            r_ptr <= w_cmd_idx;
            // A zero-length command is consumed without leaving IDLE.
            if (cmd_req_i.len != '0) begin
              r_cmd_ready <= 1'b0;
              if (cmd_req_i.is_write) begin
                r_state  <= EMU_WR;
                r_wready <= 1'b1;
              end else begin
                r_state <= EMU_RD_WAIT;
                r_lat   <= LatW'(ReadLatency);
              end
            end
          end
        end
        EMU_WR: begin
          if (w_wr_fire) begin
            r_ptr <= r_ptr + IdxW'(1);
            r_cnt <= r_cnt - dram_beat_cnt_t'(1);
            if (w_cnt_last) begin
              r_state     <= EMU_IDLE;
              r_wready    <= 1'b0;
              r_cmd_ready <= 1'b1;
            end
          end
        end
        EMU_RD_WAIT: begin
          if (r_lat == '0) begin
            r_state  <= EMU_RD_DATA;
            r_rvalid <= 1'b1;
            r_rlast  <= w_cnt_last;
          end else begin
            r_lat <= r_lat - LatW'(1);
          end
        end
        EMU_RD_DATA: begin
          if (w_rd_fire) begin
            if (w_cnt_last) begin
              r_state     <= EMU_IDLE;
              r_rvalid    <= 1'b0;
              r_rlast     <= 1'b0;
              r_cmd_ready <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + IdxW'(1);
              r_cnt   <= r_cnt - dram_beat_cnt_t'(1);
              r_rlast <= (r_cnt == dram_beat_cnt_t'(2));
            end
          end
        end
        default: begin
          r_state <= EMU_IDLE;
        end
      endcase
    end
  end

  // Read data is the memory's output register, forced to zero when no beat
  // is being presented; it only changes on a fetch, so it holds under stall.
  always_comb begin
    cmd_rsp_o.cmd_ready    = r_cmd_ready;
    phy_rsp_o.w_data_ready = r_wready;
    phy_rsp_o.r_data_valid = r_rvalid;
    phy_rsp_o.r_data       = r_rvalid ? w_mem_rdata : '0;
    phy_rsp_o.r_data_last  = r_rlast;
  end

  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rpc_phy_emu.sv
// Directed bench for rpc_phy_emu: write/read bursts, backpressure, address
// wrap, zero-length commands and reset in the middle of a burst.
module tb_rpc_phy_emu;
  import rpc_phy_emu_pkg::*;

  localparam int unsigned Depth = 1024;
  localparam int unsigned RL    = 4;

  logic         clk;
  logic         rst;
  axi_cmd_req_t cmd_req;
  axi_cmd_rsp_t cmd_rsp;
  phy_req_t     phy_req;
  phy_rsp_t     phy_rsp;
  emu_state_e   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] exp_q[$];

  dram_word_t wa, wb, wc, wx, wy, wz, wp, wq;

  rpc_phy_emu #(
    .Depth       (Depth),
    .ReadLatency (RL)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_req_i   (cmd_req),
    .cmd_rsp_o   (cmd_rsp),
    .phy_req_i   (phy_req),
    .phy_rsp_o   (phy_rsp),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [259:0] got, input logic [259:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] len, input logic [19:0] addr);
    int w;
    w = 0;
    while (!cmd_rsp.cmd_ready && w < 20) begin
      tick();
      w++;
    end
    check_eq("cmd_ready_before_accept", {259'd0, cmd_rsp.cmd_ready}, 260'd1);
    cmd_req.cmd_valid = 1'b1;
    cmd_req.is_write  = wr;
    cmd_req.len       = len;
    cmd_req.addr      = addr;
    tick();
    cmd_req.cmd_valid = 1'b0;
  endtask

  task automatic write_beat(input dram_word_t d);
    check_eq("w_ready", {259'd0, phy_rsp.w_data_ready}, 260'd1);
    phy_req.w_data_valid = 1'b1;
    phy_req.w_data       = d;
    tick();
    phy_req.w_data_valid = 1'b0;
  endtask

  // Call right after the read command is accepted; beats come from exp_q.
  task automatic read_burst(input int n, input int stall0);
    int lat;
    logic [255:0] exp;
    lat = 1;
    while (!phy_rsp.r_data_valid && lat < 50) begin
      tick();
      lat++;
    end
    check_eq("rd_first_valid_latency", 260'(lat), 260'(RL + 2));
    for (int i = 0; i < n; i++) begin
      exp = exp_q.pop_front();
      if (i == 0) begin
        for (int s = 0; s < stall0; s++) begin
          phy_req.r_data_ready = 1'b0;
          check_eq("stall_valid", {259'd0, phy_rsp.r_data_valid}, 260'd1);
          check_eq("stall_data", {4'd0, phy_rsp.r_data}, {4'd0, exp});
          check_eq("stall_last", {259'd0, phy_rsp.r_data_last}, {259'd0, (i == n - 1)});
          tick();
        end
      end
      phy_req.r_data_ready = 1'b1;
      check_eq("beat_valid", {259'd0, phy_rsp.r_data_valid}, 260'd1);
      check_eq("beat_data", {4'd0, phy_rsp.r_data}, {4'd0, exp});
      check_eq("beat_last", {259'd0, phy_rsp.r_data_last}, {259'd0, (i == n - 1)});
      tick();
    end
    phy_req.r_data_ready = 1'b0;
    check_eq("rd_done_valid_low", {259'd0, phy_rsp.r_data_valid}, 260'd0);
    check_eq("rd_done_cmd_ready", {259'd0, cmd_rsp.cmd_ready}, 260'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, {259'd0, cmd_rsp.cmd_ready}, 260'd1);
    check_eq({tag, "_w_ready"}, {259'd0, phy_rsp.w_data_ready}, 260'd0);
    check_eq({tag, "_r_valid"}, {259'd0, phy_rsp.r_data_valid}, 260'd0);
    check_eq({tag, "_r_last"}, {259'd0, phy_rsp.r_data_last}, 260'd0);
    check_eq({tag, "_r_data"}, {4'd0, phy_rsp.r_data}, 260'd0);
    check_eq({tag, "_state"}, {258'd0, dbg_state}, {258'd0, EMU_IDLE});
  endtask

  initial begin
    int seen;
    wa = {8{32'hA0A0_0001}};
    wb = {8{32'hB1B1_0002}};
    wc = {8{32'hC2C2_0003}};
    wx = {8{32'h5858_1111}};
    wy = {8{32'h5959_2222}};
    wz = {8{32'h5A5A_3333}};
    wp = {8{32'h5050_4444}};
    wq = {8{32'h5151_5555}};

    cmd_req = '0;
    phy_req = '0;
    rst     = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Write A,B,C at 0x10 with a 2-cycle stall after A.
    send_cmd(1'b1, 6'd3, 20'h00010);
    check_eq("wr_state", {258'd0, dbg_state}, {258'd0, EMU_WR});
    check_eq("wr_cmd_ready_low", {259'd0, cmd_rsp.cmd_ready}, 260'd0);
    write_beat(wa);
    tick();
    check_eq("wr_stall_ready", {259'd0, phy_rsp.w_data_ready}, 260'd1);
    tick();
    write_beat(wb);
    write_beat(wc);
    check_eq("wr_done_cmd_ready", {259'd0, cmd_rsp.cmd_ready}, 260'd1);
    check_eq("wr_done_w_ready", {259'd0, phy_rsp.w_data_ready}, 260'd0);

    // Read back A,B,C, no backpressure.
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    exp_q.push_back(wc);
    send_cmd(1'b0, 6'd3, 20'h00010);
    read_burst(3, 0);

    // Backpressure on beat 0 of a 2-beat read.
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    send_cmd(1'b0, 6'd2, 20'h00010);
    read_burst(2, 5);

    // Wrap: write X,Y at 0x3FF -> indices 1023, 0.
    send_cmd(1'b1, 6'd2, 20'h003FF);
    write_beat(wx);
    write_beat(wy);
    exp_q.push_back(wy);
    send_cmd(1'b0, 6'd1, 20'h00000);
    read_burst(1, 0);
    exp_q.push_back(wx);
    send_cmd(1'b0, 6'd1, 20'h003FF);
    read_burst(1, 0);

    // Upper address bits alias: 0xFFC00 is index 0.
    send_cmd(1'b1, 6'd1, 20'hFFC00);
    write_beat(wz);
    exp_q.push_back(wz);
    send_cmd(1'b0, 6'd1, 20'h00000);
    read_burst(1, 0);

    // Zero-length read, then a real read right behind it.
    send_cmd(1'b0, 6'd0, 20'h00010);
    check_eq("zero_len_cmd_ready", {259'd0, cmd_rsp.cmd_ready}, 260'd1);
    check_eq("zero_len_state", {258'd0, dbg_state}, {258'd0, EMU_IDLE});
    exp_q.push_back(wx);
    send_cmd(1'b0, 6'd1, 20'h003FF);
    read_burst(1, 0);

    // Zero-length read on its own: no beat may ever appear.
    send_cmd(1'b0, 6'd0, 20'h00010);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (phy_rsp.r_data_valid) seen++;
      tick();
    end
    check_eq("zero_len_no_valid", 260'(seen), 260'd0);

    // Reset in the middle of a 4-beat write after P,Q.
    send_cmd(1'b1, 6'd4, 20'h00020);
    write_beat(wp);
    write_beat(wq);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    exp_q.push_back(wp);
    exp_q.push_back(wq);
    send_cmd(1'b0, 6'd2, 20'h00020);
    read_burst(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
